// File: rtl/dclick_gen_if.sv
// Command/status bundle between the pulse-sequencer core and dclick_gen.
interface dclick_gen_if;
  logic        wTrig_i;
  logic [15:0] wStep_i;
  logic [15:0] wDelay_i;
  logic        wHlvl_i;
  logic        wClr_i;
  logic        rClk_o;
  logic        wReady_o;
  logic        rDone_o;
  logic [31:0] rClicks_o;
  logic        rOvr_o;

  // Core side: issues commands, watches ready/done.
  modport master (
    output wTrig_i, wStep_i, wDelay_i, wHlvl_i, wClr_i,
    input  rClk_o, wReady_o, rDone_o, rClicks_o, rOvr_o
  );

  // Generator side.
  modport slave (
    input  wTrig_i, wStep_i, wDelay_i, wHlvl_i, wClr_i,
    output rClk_o, wReady_o, rDone_o, rClicks_o, rOvr_o
  );
endinterface

// File: rtl/dclick_gen.sv
// Digital-click pulse-train generator: emits Step clicks of half-period Delay
// on a registered output line, holding ready low until the train completes.
module dclick_gen #(
  parameter int DMIN = 2
) (
  input  logic          wClk_i,
  input  logic          wReset_i,
  dclick_gen_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      r_state, w_nstate;
  logic [15:0] r_cnt, w_ncnt;     // phase counter, counts down to 0
  logic [15:0] r_rem, w_nrem;     // clicks remaining in this train
  logic [15:0] r_dly, w_ndly;     // latched, clamped half-period
  logic        r_lvl, w_nlvl;     // latched level: 0 runs silently
  logic        r_clk, w_nclk;
  logic        r_done, w_ndone;
  logic [31:0] r_clicks;
  logic        r_ovr;
  logic        w_inc;             // a real click completes this cycle
  logic        w_ovr_set;         // trigger arrived while busy
  logic [15:0] w_dclamp;

  // Clamp requested half-period up to the minimum honoured value.
  assign w_dclamp  = (bus.wDelay_i < 16'(DMIN)) ? 16'(DMIN) : bus.wDelay_i;
  assign w_ovr_set = bus.wTrig_i && (r_state != IDLE);

  // Next-state and next-output logic for the click FSM.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nrem   = r_rem;
    w_ndly   = r_dly;
    w_nlvl   = r_lvl;
    w_nclk   = r_clk;
    w_ndone  = 1'b0;
    w_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.wTrig_i) begin
          if (bus.wStep_i != 16'd0) begin
            w_nrem   = bus.wStep_i;
            w_ndly   = w_dclamp;
            w_nlvl   = bus.wHlvl_i;
            w_ncnt   = w_dclamp - 16'd1;
            w_nclk   = bus.wHlvl_i;
            w_nstate = HIGH;
          end else begin
            w_ndone = 1'b1;
          end
        end
      end
      HIGH: begin
        if (r_cnt == 16'd0) begin
          w_inc    = r_lvl;
          w_ncnt   = r_dly - 16'd1;
          w_nclk   = 1'b0;
          w_nstate = LOW;
        end else begin
          w_ncnt = r_cnt - 16'd1;
        end
      end
      LOW: begin
        if (r_cnt == 16'd0) begin
          w_nrem = r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            w_ndone  = 1'b1;
            w_nstate = IDLE;
          end else begin
            w_ncnt   = r_dly - 16'd1;
            w_nclk   = r_lvl;
            w_nstate = HIGH;
          end
        end else begin
          w_ncnt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_nclk   = 1'b0;
        w_nstate = IDLE;
      end
    endcase
  end

  // FSM state, train context and registered click/done outputs.
  always_ff @(posedge wClk_i or posedge wReset_i) begin
    if (wReset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dly   <= '0;
      r_lvl   <= 1'b0;
      r_clk   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_rem   <= w_nrem;
      r_dly   <= w_ndly;
      r_lvl   <= w_nlvl;
      r_clk   <= w_nclk;
      r_done  <= w_ndone;
    end
  end

  // Status counters; a same-cycle clear beats increment and overflow set.
  always_ff @(posedge wClk_i or posedge wReset_i) begin
    if (wReset_i) begin
      r_clicks <= '0;
      r_ovr    <= 1'b0;
    end else if (bus.wClr_i) begin
      r_clicks <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_inc)     r_clicks <= r_clicks + 32'd1;
      if (w_ovr_set) r_ovr    <= 1'b1;
    end
  end

  assign bus.rClk_o    = r_clk;
  assign bus.wReady_o  = (r_state == IDLE);
  assign bus.rDone_o   = r_done;
  assign bus.rClicks_o = r_clicks;
  assign bus.rOvr_o    = r_ovr;
endmodule
